rdf: RTL

Read data flow buffer for the memory controller: the return-path counterpart of the write data flow. The SRQ allocates one of 8 slots when it issues a memory read. The DFI returns read data in issue order, and the block writes each beat into the allocated slot. The TLX transmitter then reads slots out by pointer, which frees them.

---
 rtl/rdf.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rdf.sv
// Read data flow buffer: 8 x 64-bit slots filled in issue order by DFI, drained by TLX pointer reads.
// Latency: tlxt read to data 2 cycles. No backpressure; illegal commands are dropped and flagged. Option: RDF_DATA_PARITY_EN.
module rdf (
  input  logic        clk,
  input  logic        rst,
  input  logic        srq_rdf_rd,
  input  logic [2:0]  srq_rdf_ptr,
  input  logic        srq_rdf_p,
  input  logic        dfi_rdf_valid,
  input  logic [63:0] dfi_rdf_data,
`ifdef RDF_DATA_PARITY_EN
  input  logic [7:0]  dfi_rdf_data_p,
`endif
  input  logic        tlxt_rdf_rd,
  input  logic [2:0]  tlxt_rdf_ptr,
  input  logic        tlxt_rdf_p,
  output logic        rdf_tlxt_valid,
  output logic [63:0] rdf_tlxt_data,
  output logic [7:0]  rdf_srq_free,
`ifdef RDF_DATA_PARITY_EN
  output logic [5:0]  rdf_fir
`else
  output logic [4:0]  rdf_fir
`endif
);

`ifdef RDF_DATA_PARITY_EN
  localparam int FIR_W = 6;
`else
  localparam int FIR_W = 5;
`endif

  typedef enum logic [1:0] {S_FREE, S_PEND, S_READY} slot_st_t;

  slot_st_t    st     [8];
  slot_st_t    st_nxt [8];
  logic [63:0] mem    [8];
  logic [2:0]  ord_mem [8];
  logic [3:0]  ord_wp, ord_rp;

  logic        srq_cmd, srq_par_err, alloc_ok, alloc_err;
  logic        tlxt_cmd, tlxt_par_err, rd_ok, rd_err;
  logic        fifo_empty, fill, fill_err;
  logic [2:0]  head;
  logic [63:0] rd_dat;
  logic [FIR_W-1:0] fir_evt;
  logic        s1_vld;
  logic [63:0] s1_dat;

`ifdef RDF_DATA_PARITY_EN
  logic [7:0] poison;
  logic       dpar_err;

  always_comb begin
    dpar_err = 1'b0;
    for (int b = 0; b < 8; b++)
      dpar_err = dpar_err | (^{dfi_rdf_data[8*b +: 8], dfi_rdf_data_p[b]});
  end
`endif

  // Legality is judged only against the slot state held at the start of the cycle.
  always_comb begin
    srq_par_err  = srq_rdf_rd & (^{srq_rdf_rd, srq_rdf_p, srq_rdf_ptr});
    srq_cmd      = srq_rdf_rd & ~(^{srq_rdf_rd, srq_rdf_p, srq_rdf_ptr});
    alloc_ok     = srq_cmd && (st[srq_rdf_ptr] == S_FREE);
    alloc_err    = srq_cmd && (st[srq_rdf_ptr] != S_FREE);
    tlxt_par_err = tlxt_rdf_rd & (^{tlxt_rdf_rd, tlxt_rdf_p, tlxt_rdf_ptr});
    tlxt_cmd     = tlxt_rdf_rd & ~(^{tlxt_rdf_rd, tlxt_rdf_p, tlxt_rdf_ptr});
    rd_ok        = tlxt_cmd && (st[tlxt_rdf_ptr] == S_READY);
    rd_err       = tlxt_cmd && (st[tlxt_rdf_ptr] != S_READY);
    fifo_empty   = (ord_wp == ord_rp);
    fill         = dfi_rdf_valid & ~fifo_empty;
    fill_err     = dfi_rdf_valid & fifo_empty;
    head         = ord_mem[ord_rp[2:0]];
  end

  always_comb begin
    fir_evt      = '0;
    fir_evt[0]   = srq_par_err;
    fir_evt[1]   = tlxt_par_err;
    fir_evt[2]   = alloc_err;
    fir_evt[3]   = fill_err;
    fir_evt[4]   = rd_err;
`ifdef RDF_DATA_PARITY_EN
    fir_evt[5]   = fill & dpar_err;
`endif
  end

  // The three transitions require mutually exclusive current states, so they never collide on a slot.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      st_nxt[i] = st[i];
      if (alloc_ok && (srq_rdf_ptr == 3'(i)))
        st_nxt[i] = S_PEND;
      if (fill && (head == 3'(i)))
        st_nxt[i] = S_READY;
      if (rd_ok && (tlxt_rdf_ptr == 3'(i)))
        st_nxt[i] = S_FREE;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++)
      rdf_srq_free[i] = (st[i] == S_FREE);
  end

  always_comb begin
    rd_dat = mem[tlxt_rdf_ptr];
`ifdef RDF_DATA_PARITY_EN
    if (poison[tlxt_rdf_ptr])
      rd_dat = 64'hDEAD_DEAD_DEAD_DEAD;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        st[i] <= S_FREE;
      ord_wp         <= '0;
      ord_rp         <= '0;
      rdf_fir        <= '0;
      s1_vld         <= 1'b0;
      s1_dat         <= '0;
      rdf_tlxt_valid <= 1'b0;
      rdf_tlxt_data  <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        st[i] <= st_nxt[i];
      if (alloc_ok)
        ord_wp <= ord_wp + 4'd1;
      if (fill)
        ord_rp <= ord_rp + 4'd1;
      rdf_fir        <= rdf_fir | fir_evt;
      s1_vld         <= rd_ok;
      s1_dat         <= rd_ok ? rd_dat : 64'd0;
      rdf_tlxt_valid <= s1_vld;
      rdf_tlxt_data  <= s1_dat;
    end
  end

  // Storage arrays carry no reset; slot state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (alloc_ok)
      ord_mem[ord_wp[2:0]] <= srq_rdf_ptr;
    if (fill)
      mem[head] <= dfi_rdf_data;
  end

`ifdef RDF_DATA_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)
      poison <= '0;
    else if (fill)
      poison[head] <= dpar_err;
  end
`endif

endmodule
